uart_tx_arbiter: RTL and testbench
==================================

// Module: uart_tx_arbiter
// PURPOSE
//  Shares one uart_tx serializer among NUM_REQ byte producers (debug console, test-status
//  reporter, loopback echo, ...). Round-robin arbitration on packet boundaries; a granted
//  requester keeps the line until it presents a byte tagged last. Launches one byte per
//  frame via tx_start/tx_din, waits for tx_done, and flags a stuck serializer with a watchdog.
// PARAMETERS
//  NUM_REQ         4        number of requesters, 2..8
//  TIMEOUT_CYCLES  1<<20    clk cycles allowed in WAIT_DONE before timeout abort
// PORTS
//  clk          in   1            system clock
//  rst          in   1            synchronous reset, active-high
//  req_valid    in   NUM_REQ      requester i has a byte in req_data[8*i+:8]
//  req_data     in   8*NUM_REQ    byte per requester, LSB-first slicing
//  req_last     in   NUM_REQ      byte ends requester i's packet (releases lock)
//  req_ready    out  NUM_REQ      one-hot, 1-cycle accept strobe for requester i
//  tx_start     out  1            to uart_tx.tx_start, 1-cycle pulse
//  tx_din       out  8            to uart_tx.din, stable from launch until tx_done
//  tx_done      in   1            from uart_tx.tx_done, 1-cycle pulse at end of stop bit
//  grant_id     out  $clog2(NUM_REQ)  current/last owner index
//  busy         out  1            1 in any state other than IDLE, or while locked
//  err_timeout  out  1            sticky watchdog flag
//  err_clr      in   1            clears err_timeout
// BEHAVIOUR
//  Reset (rst=1 at clk edge): state=IDLE, rr_ptr=0, lock=0, grant_id=0, tx_start=0,
//   tx_din=0, req_ready=0, busy=0, err_timeout=0, wd_cnt=0. Mid-frame reset aborts without
//   completion; uart_tx shares the same reset. tx_done seen in IDLE is ignored.
//  FSM states: IDLE, LAUNCH, WAIT_DONE.
//  IDLE: if lock=0, grant = first i with req_valid[i] searching rr_ptr, rr_ptr+1, ... mod
//   NUM_REQ. If lock=1, only the locked owner is eligible; other requesters wait even when
//   the owner has req_valid=0. When a grant exists: req_ready[g]=1 this cycle (combinational
//   off registered state); capture req_data[g] into tx_din, req_last[g] into last_q,
//   grant_id<=g, lock<=1; next state LAUNCH. No grant: stay in IDLE, req_ready=0.
//  LAUNCH: tx_start=1 for exactly this cycle; wd_cnt<=0; next state WAIT_DONE.
//  WAIT_DONE: tx_start=0; wd_cnt increments each cycle. On tx_done: if last_q, lock<=0 and
//   rr_ptr<=grant_id+1 (wraps at NUM_REQ to 0); next state IDLE. Else if
//   wd_cnt==TIMEOUT_CYCLES-1: err_timeout<=1, lock<=0, rr_ptr<=grant_id+1, and IDLE.
//   tx_done wins if both occur in the same cycle.
//  Latency: accept -> tx_start is 1 cycle. tx_done -> next req_ready is at least 1 cycle
//   (IDLE cycle). uart_tx is back in IDLE at that point, so its tx_start is honoured.
//   Throughput is one byte per frame plus 2 clk.
//  tx_din holds the captured byte until the next accept and is never changed in
//   LAUNCH/WAIT_DONE.
//  err_timeout: set has priority over err_clr in the same cycle. The flag never blocks
//   operation.
//  req_valid/req_data may change freely while req_ready=0. No byte is consumed without a
//   req_ready strobe.
//  busy = (state!=IDLE) | lock.
// TESTING
//  1 Single req0 byte 0xA5 last=1 -> ready[0] 1 cycle, tx_start next cycle, tx_din=0xA5;
//    after tx_done, busy=0 and rr_ptr=1.
//  2 req0..3 all valid with last=1 -> grants in order 0,1,2,3,0. Each byte is sent once.
//    No overlapping tx_start.
//  3 req1 sends 3 bytes (last on 3rd) while req2 stays valid -> req2 is granted only after
//    req1's 3rd tx_done.
//  4 Locked req1 drops valid for 50 cycles -> req0/req2 stay unserved. Grant resumes to
//    req1 when its valid returns.
//  5 TIMEOUT_CYCLES=64, tx_done withheld -> err_timeout=1 at cycle 64 of WAIT_DONE. IDLE and
//    lock released; err_clr clears the flag.
//  6 rst asserted during WAIT_DONE -> all outputs at reset values next cycle. A stray
//    tx_done in IDLE causes no grant.
//  Scoreboard: byte order per requester; uart_tx line decoded back equals the bytes sent.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx serializer among NUM_REQ byte producers: round-robin on packet
// boundaries, one byte per frame (accept -> tx_start -> tx_done), watchdog on a stuck frame.
module uart_tx_arbiter #(
  parameter int  NUM_REQ        = 4,
  parameter int  TIMEOUT_CYCLES = 1 << 20,
  localparam int GW             = $clog2(NUM_REQ),
  localparam int WW             = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_din,
  input  logic                 tx_done,
  output logic [GW-1:0]        grant_id,
  output logic                 busy,
  output logic                 err_timeout,
  input  logic                 err_clr
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_DONE} state_e;

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d, grant_id_q, grant_id_d;
  logic          lock_q, lock_d, last_q, last_d;
  logic          tx_start_q, tx_start_d, err_q, err_d;
  logic [7:0]    tx_din_q, tx_din_d;
  logic [WW-1:0] wd_cnt_q, wd_cnt_d;

  logic          gnt_vld;
  logic [GW-1:0] gnt_idx, scan_idx, next_ptr;
  logic [7:0]    sel_data;
  logic          sel_last;

  // Scan from the highest offset down so the requester closest to rr_ptr wins.
  always_comb begin : arb
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (lock_q) begin
      gnt_vld = req_valid[grant_id_q];
      gnt_idx = grant_id_q;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_idx = GW'((int'(rr_ptr_q) + k) % NUM_REQ);
        if (req_valid[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin : mux
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt_idx == GW'(i)) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  assign next_ptr = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin : fsm
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    lock_d     = lock_q;
    last_d     = last_q;
    tx_start_d = 1'b0;
    tx_din_d   = tx_din_q;
    wd_cnt_d   = wd_cnt_q;
    err_d      = err_q & ~err_clr;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          tx_din_d   = sel_data;
          last_d     = sel_last;
          grant_id_d = gnt_idx;
          lock_d     = 1'b1;
          tx_start_d = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        wd_cnt_d = '0;
        state_d  = WAIT_DONE;
      end
      WAIT_DONE: begin
        wd_cnt_d = wd_cnt_q + 1'b1;
        if (tx_done) begin
          state_d = IDLE;
          if (last_q) begin
            lock_d   = 1'b0;
            rr_ptr_d = next_ptr;
          end
        end else if (wd_cnt_q == WW'(TIMEOUT_CYCLES - 1)) begin
          err_d    = 1'b1;
          lock_d   = 1'b0;
          rr_ptr_d = next_ptr;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      lock_q     <= 1'b0;
      last_q     <= 1'b0;
      tx_start_q <= 1'b0;
      tx_din_q   <= '0;
      wd_cnt_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      lock_q     <= lock_d;
      last_q     <= last_d;
      tx_start_q <= tx_start_d;
      tx_din_q   <= tx_din_d;
      wd_cnt_q   <= wd_cnt_d;
      err_q      <= err_d;
    end
  end

  // A strobe while rst is high would promise a byte the reset edge then discards.
  always_comb begin : rdy
    req_ready = '0;
    if (state_q == IDLE && gnt_vld && !rst) req_ready[gnt_idx] = 1'b1;
  end

  assign tx_start    = tx_start_q;
  assign tx_din      = tx_din_q;
  assign grant_id    = grant_id_q;
  assign busy        = (state_q != IDLE) | lock_q;
  assign err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench: requester queues feed the arbiter, a serializer model decodes the
// line back, and a monitor compares each decoded byte/owner against the expected queue.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 64;

  typedef struct { int id; logic [7:0] data; } item_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_din;
  logic           tx_done;
  logic [1:0]     grant_id;
  logic           busy;
  logic           err_timeout;
  logic           err_clr = 1'b0;
  logic           model_done = 1'b0;
  logic           stray_done = 1'b0;
  logic           line = 1'b1;

  int    n_cmp = 0, n_bad = 0, starts = 0;
  logic  [8:0] rq [N][$];
  bit    hold [N];
  bit    suppress = 1'b0;
  bit    prev_rdy = 1'b0;
  item_t exp_q[$], obs_q[$];

  assign tx_done = model_done | stray_done;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
    .req_ready(req_ready), .tx_start(tx_start), .tx_din(tx_din), .tx_done(tx_done),
    .grant_id(grant_id), .busy(busy), .err_timeout(err_timeout), .err_clr(err_clr)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic send(input int id, input logic [7:0] d, input bit last, input bit expect_out);
    item_t it;
    rq[id].push_back({last, d});
    if (expect_out) begin
      it.id = id; it.data = d;
      exp_q.push_back(it);
    end
  endtask

  function automatic int pending();
    int s = 0;
    for (int i = 0; i < N; i++) s += rq[i].size();
    return s;
  endfunction

  task automatic wait_drain(input string nm);
    int c = 0;
    while ((exp_q.size() != 0 || obs_q.size() != 0 || pending() != 0) && c < 2000) begin
      @(negedge clk); c++;
    end
    chk(nm, 32'(c < 2000), 1);
    @(negedge clk); #2;
  endtask

  task automatic wait_ready(input string nm);
    int c = 0;
    #2;
    while (req_ready == '0 && c < 200) begin @(negedge clk); #2; c++; end
    chk(nm, 32'(req_ready != '0), 1);
  endtask

  task automatic wait_start(input string nm);
    int c = 0;
    #2;
    while (!tx_start && c < 200) begin @(negedge clk); #2; c++; end
    chk(nm, 32'(tx_start), 1);
  endtask

  // Requester driver: present queue heads, pop on a ready strobe, check accept->start latency.
  initial begin : drv
    logic [8:0] hd;
    forever begin
      @(negedge clk);
      if (tx_start) starts++;
      if (prev_rdy || tx_start) chk("accept_to_start", 32'(tx_start), 32'(prev_rdy));
      for (int i = 0; i < N; i++) begin
        if (rq[i].size() > 0 && !hold[i]) begin
          hd = rq[i][0];
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = hd[7:0];
          req_last[i] = hd[8];
        end else begin
          req_valid[i] = 1'b0;
          req_data[8*i +: 8] = 8'hFF;
          req_last[i] = 1'b1;
        end
      end
      #1;
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 1);
        chk("ready_single_cycle", 32'(prev_rdy), 0);
        for (int i = 0; i < N; i++)
          if (req_ready[i] && rq[i].size() > 0) void'(rq[i].pop_front());
      end
      prev_rdy = (req_ready != '0);
    end
  end

  // uart_tx model: 10-bit frame, 2 clk per bit, decoded from the line it drives.
  initial begin : uart_model
    bit         act;
    bit         stable;
    logic [9:0] sh, rx;
    logic [7:0] din0;
    int         ph, nb, gid;
    item_t      it;
    act = 1'b0;
    forever begin
      @(negedge clk); #1;
      model_done = 1'b0;
      if (rst) begin
        act = 1'b0; line = 1'b1;
      end else if (tx_start) begin
        chk("no_overlap_start", 32'(act), 0);
        if (!suppress) begin
          act = 1'b1; stable = 1'b1;
          sh = {1'b1, tx_din, 1'b0}; din0 = tx_din; gid = int'(grant_id);
          ph = 0; nb = 0; rx = '0; line = sh[0];
        end
      end else if (act) begin
        stable &= (tx_din === din0);
        ph++;
        if (ph == 2) begin
          ph = 0;
          rx = {line, rx[9:1]};
          sh = sh >> 1;
          nb++;
          if (nb == 10) begin
            act = 1'b0; line = 1'b1; model_done = 1'b1;
            chk("frame_start_stop", 32'({rx[9], rx[0]}), 32'b10);
            chk("tx_din_stable", 32'(stable), 1);
            it.id = gid; it.data = rx[8:1];
            obs_q.push_back(it);
          end else begin
            line = sh[0];
          end
        end
      end
    end
  end

  initial begin : monitor
    item_t o, e;
    forever begin
      @(posedge clk);
      while (obs_q.size() > 0) begin
        o = obs_q.pop_front();
        chk("sb_has_entry", 32'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("owner_id", o.id, e.id);
          chk("line_byte", 32'(o.data), 32'(e.data));
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : main
    int s0;
    for (int i = 0; i < N; i++) hold[i] = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_tx_start", 32'(tx_start), 0);
    chk("rst_tx_din", 32'(tx_din), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(err_timeout), 0);
    rst = 1'b0;
    @(negedge clk);

    // 1: single byte, ready then start one cycle later
    send(0, 8'hA5, 1'b1, 1'b1);
    wait_ready("t1_ready_seen");
    chk("t1_ready", 32'(req_ready), 32'b0001);
    @(negedge clk); #2;
    chk("t1_ready_drop", 32'(req_ready), 0);
    chk("t1_start", 32'(tx_start), 1);
    chk("t1_din", 32'(tx_din), 32'hA5);
    chk("t1_busy", 32'(busy), 1);
    wait_drain("t1_drain");
    chk("t1_idle", 32'(busy), 0);
    chk("t1_rr_ptr", 32'(dut.rr_ptr_q), 1);

    // 2: all four valid from rr_ptr=0 -> 0,1,2,3,0
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    chk("t2_rr_reset", 32'(dut.rr_ptr_q), 0);
    send(0, 8'h11, 1'b1, 1'b1);
    send(1, 8'h22, 1'b1, 1'b1);
    send(2, 8'h33, 1'b1, 1'b1);
    send(3, 8'h44, 1'b1, 1'b1);
    send(0, 8'h55, 1'b1, 1'b1);
    exp_q.delete();
    begin
      item_t it;
      it.id = 0; it.data = 8'h11; exp_q.push_back(it);
      it.id = 1; it.data = 8'h22; exp_q.push_back(it);
      it.id = 2; it.data = 8'h33; exp_q.push_back(it);
      it.id = 3; it.data = 8'h44; exp_q.push_back(it);
      it.id = 0; it.data = 8'h55; exp_q.push_back(it);
    end
    wait_drain("t2_drain");
    chk("t2_rr_ptr", 32'(dut.rr_ptr_q), 1);

    // 3: three-byte packet on req1 holds off req2
    send(1, 8'h61, 1'b0, 1'b1);
    send(1, 8'h62, 1'b0, 1'b1);
    send(1, 8'h63, 1'b1, 1'b1);
    send(2, 8'h70, 1'b1, 1'b1);
    wait_drain("t3_drain");
    chk("t3_busy", 32'(busy), 0);

    // 4: locked owner goes quiet, others must wait
    send(1, 8'h81, 1'b0, 1'b1);
    wait_drain("t4_first");
    chk("t4_locked_busy", 32'(busy), 1);
    chk("t4_owner", 32'(grant_id), 1);
    hold[1] = 1'b1;
    send(1, 8'h82, 1'b1, 1'b1);
    send(2, 8'hA0, 1'b1, 1'b1);
    send(0, 8'h90, 1'b1, 1'b1);
    s0 = starts;
    repeat (50) @(negedge clk);
    #2;
    chk("t4_no_start", 32'(starts - s0), 0);
    chk("t4_no_ready", 32'(req_ready), 0);
    chk("t4_still_busy", 32'(busy), 1);
    hold[1] = 1'b0;
    wait_drain("t4_drain");
    chk("t4_busy", 32'(busy), 0);

    // 5: withheld tx_done -> watchdog after 64 WAIT_DONE cycles
    suppress = 1'b1;
    send(3, 8'hC3, 1'b1, 1'b0);
    wait_start("t5_start");
    repeat (64) @(negedge clk);
    #2;
    chk("t5_err_early", 32'(err_timeout), 0);
    @(negedge clk); #2;
    chk("t5_err_set", 32'(err_timeout), 1);
    chk("t5_released", 32'(busy), 0);
    chk("t5_owner", 32'(grant_id), 3);
    chk("t5_rr_wrap", 32'(dut.rr_ptr_q), 0);
    suppress = 1'b0;
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #2;
    chk("t5_err_clr", 32'(err_timeout), 0);

    // 6: reset mid-frame, then a stray tx_done in IDLE
    send(0, 8'hD6, 1'b1, 1'b1);
    wait_start("t6_start");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #2;
    chk("t6_ready", 32'(req_ready), 0);
    chk("t6_start", 32'(tx_start), 0);
    chk("t6_din", 32'(tx_din), 0);
    chk("t6_gid", 32'(grant_id), 0);
    chk("t6_busy", 32'(busy), 0);
    chk("t6_err", 32'(err_timeout), 0);
    rst = 1'b0;
    exp_q.delete();
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    s0 = starts;
    repeat (5) @(negedge clk);
    #2;
    chk("t6_stray_no_start", 32'(starts - s0), 0);
    chk("t6_stray_idle", 32'(busy), 0);
    chk("sb_empty", 32'(exp_q.size() + obs_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
